// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory request/response plus the decode valid/ready handshake.
// master is the fetch controller; slave is memory plus decode.
interface inst_fetch_ctrl_if;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    output mem_address,
    input  mem_instruction,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  modport slave (
    input  mem_address,
    output mem_instruction,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: holds each address MEM_LATENCY cycles, buffers {pc, instruction}
// in a prefetch FIFO for decode, and flushes on redirect.
module inst_fetch_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         fetch_count,
  inst_fetch_ctrl_if.master   bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [PtrW:0]   OccFull = (PtrW + 1)'(DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LATENCY - 1);

  typedef enum logic [0:0] {StFetch, StFull} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     count_q, count_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   occ_q, occ_d;
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic            push, pop;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    pop        = (occ_q != '0) && bus.inst_ready;
    push       = 1'b0;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    if (redirect) begin
      // Flush wins over any completing fetch and any same-cycle pop.
      state_d    = StFetch;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      occ_d      = '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (cnt_q == LastCnt && occ_q != OccFull) begin
            push       = 1'b1;
            cnt_d      = '0;
            fetch_pc_d = fetch_pc_q + 32'd4;
            count_d    = count_q + 32'd1;
          end else if (cnt_q != LastCnt) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StFull: begin
          if (pop) cnt_d = '0;
        end
        default: ;
      endcase
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      occ_d = occ_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
      if (state_q == StFetch) state_d = (occ_d == OccFull) ? StFull : StFetch;
      else if (pop)           state_d = StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wptr_q]  <= fetch_pc_q;
      ins_mem[wptr_q] <= bus.mem_instruction;
    end
  end

  assign bus.mem_address = fetch_pc_q;
  assign bus.inst_valid  = (occ_q != '0);
  assign bus.inst_out    = (occ_q != '0) ? ins_mem[rptr_q] : 32'h0;
  assign bus.inst_pc     = (occ_q != '0) ? pc_mem[rptr_q]  : 32'h0;
  assign fetch_count     = count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: one single-cycle-memory instance and one 3-cycle-memory instance,
// each with a scoreboard of expected {pc, instruction} consumed on every decode pop.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1, redirect1 = 1'b0, ready1 = 1'b1;
  logic        rst3 = 1'b1, redirect3 = 1'b0, ready3 = 1'b0;
  logic [31:0] rpc1 = 32'h0, rpc3 = 32'h0;
  logic [31:0] count1, count3;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] q1 [$];
  logic [63:0] q3 [$];

  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus1 ();
  inst_fetch_ctrl_if bus3 ();

  // Memory word at each address is its word index.
  assign bus1.mem_instruction = {2'b00, bus1.mem_address[31:2]};
  assign bus3.mem_instruction = {2'b00, bus3.mem_address[31:2]};
  assign bus1.inst_ready      = ready1;
  assign bus3.inst_ready      = ready3;

  inst_fetch_ctrl #(.DEPTH(4), .MEM_LATENCY(1), .RESET_PC(32'h0000_0000)) u_dut1 (
    .clk         (clk),
    .rst         (rst1),
    .redirect    (redirect1),
    .redirect_pc (rpc1),
    .fetch_count (count1),
    .bus         (bus1)
  );

  inst_fetch_ctrl #(.DEPTH(4), .MEM_LATENCY(3), .RESET_PC(32'h0000_1000)) u_dut3 (
    .clk         (clk),
    .rst         (rst3),
    .redirect    (redirect3),
    .redirect_pc (rpc3),
    .fetch_count (count3),
    .bus         (bus3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] entry(input logic [31:0] pc);
    return {pc, {2'b00, pc[31:2]}};
  endfunction

  task automatic fill1(input logic [31:0] start);
    q1.delete();
    for (int i = 0; i < 64; i++) q1.push_back(entry(start + 32'(4 * i)));
  endtask

  task automatic fill3(input logic [31:0] start);
    q3.delete();
    for (int i = 0; i < 64; i++) q3.push_back(entry(start + 32'(4 * i)));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset1();
    check("rst1_addr", bus1.mem_address, 32'h0);
    check("rst1_cnt", count1, 32'h0);
    check("rst1_valid", {31'h0, bus1.inst_valid}, 32'h0);
    check("rst1_pc", bus1.inst_pc, 32'h0);
    check("rst1_out", bus1.inst_out, 32'h0);
  endtask

  // Scoreboard: each accepted head must match the next expected entry.
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus1.inst_valid && ready1 && !rst1 && !redirect1) begin
      if (q1.size() == 0) check("sb1_extra", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        check("sb1_pc", bus1.inst_pc, e[63:32]);
        check("sb1_ins", bus1.inst_out, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus3.inst_valid && ready3 && !rst3 && !redirect3) begin
      if (q3.size() == 0) check("sb3_extra", 32'h1, 32'h0);
      else begin
        e = q3.pop_front();
        check("sb3_pc", bus3.inst_pc, e[63:32]);
        check("sb3_ins", bus3.inst_out, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Streaming at one word per cycle.
    step(2);
    rst1 = 1'b0;
    fill1(32'h0);
    check_reset1();
    step(1);
    check("str_valid", {31'h0, bus1.inst_valid}, 32'h1);
    check("str_pc0", bus1.inst_pc, 32'h0);
    check("str_addr", bus1.mem_address, 32'h4);
    check("str_cnt", count1, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("str_sustain", {31'h0, bus1.inst_valid}, 32'h1);
      check("str_cnt_i", count1, 32'(2 + i));
      check("str_addr_i", bus1.mem_address, 32'(4 * (2 + i)));
    end

    // Backpressure into FULL, then single pop.
    rst1 = 1'b1; ready1 = 1'b0;
    step(1);
    rst1 = 1'b0;
    fill1(32'h0);
    step(6);
    check("full_cnt", count1, 32'd4);
    check("full_addr", bus1.mem_address, 32'd16);
    check("full_pc", bus1.inst_pc, 32'h0);
    ready1 = 1'b1;
    step(1);
    ready1 = 1'b0;
    check("pop_cnt", count1, 32'd4);
    check("pop_addr", bus1.mem_address, 32'd16);
    check("pop_head", bus1.inst_pc, 32'd4);
    step(1);
    check("refill_cnt", count1, 32'd5);
    check("refill_addr", bus1.mem_address, 32'd20);
    ready1 = 1'b1;
    step(8);

    // Redirect flush with FIFO holding 8..20.
    rst1 = 1'b1; ready1 = 1'b0;
    step(1);
    rst1 = 1'b0;
    fill1(32'h0);
    step(4);
    ready1 = 1'b1;
    step(2);
    ready1 = 1'b0;
    step(1);
    check("pre_redir_pc", bus1.inst_pc, 32'd8);
    check("pre_redir_cnt", count1, 32'd6);
    redirect1 = 1'b1; rpc1 = 32'h0000_0103;
    fill1(32'h100);
    step(1);
    redirect1 = 1'b0;
    check("redir_valid", {31'h0, bus1.inst_valid}, 32'h0);
    check("redir_addr", bus1.mem_address, 32'h100);
    check("redir_cnt", count1, 32'd6);
    ready1 = 1'b1;
    step(1);
    check("redir_first", bus1.inst_pc, 32'h100);
    check("redir_cnt2", count1, 32'd7);

    // Redirect coincident with a pop and a completing fetch.
    step(2);
    check("sim_addr0", bus1.mem_address, 32'h10c);
    redirect1 = 1'b1; rpc1 = 32'h200;
    fill1(32'h200);
    step(1);
    redirect1 = 1'b0;
    check("sim_valid", {31'h0, bus1.inst_valid}, 32'h0);
    check("sim_cnt", count1, 32'd9);
    check("sim_addr", bus1.mem_address, 32'h200);
    step(2);
    check("sim_cnt2", count1, 32'd11);

    // Back-to-back redirects: the last one wins.
    redirect1 = 1'b1; rpc1 = 32'h400;
    step(1);
    rpc1 = 32'h502;
    fill1(32'h500);
    step(1);
    redirect1 = 1'b0;
    check("b2b_addr", bus1.mem_address, 32'h500);
    check("b2b_valid", {31'h0, bus1.inst_valid}, 32'h0);
    step(1);
    check("b2b_pc", bus1.inst_pc, 32'h500);
    check("b2b_cnt", count1, 32'd12);

    // rst together with redirect.
    rst1 = 1'b1; redirect1 = 1'b1; rpc1 = 32'h300;
    step(1);
    rst1 = 1'b0; redirect1 = 1'b0;
    fill1(32'h0);
    check_reset1();
    step(3);
    check("post_rst_cnt", count1, 32'd3);
    check("post_rst_addr", bus1.mem_address, 32'd12);
    rst1 = 1'b1;

    // Three-cycle memory.
    ready3 = 1'b1;
    step(1);
    rst3 = 1'b0;
    fill3(32'h1000);
    check("l3_rst_addr", bus3.mem_address, 32'h1000);
    check("l3_rst_cnt", count3, 32'h0);
    for (int e = 1; e <= 30; e++) begin
      step(1);
      check("l3_addr", bus3.mem_address, 32'h1000 + 32'(4 * (e / 3)));
      check("l3_cnt", count3, 32'(e / 3));
      check("l3_valid", {31'h0, bus3.inst_valid}, (e % 3 == 0) ? 32'h1 : 32'h0);
    end

    // Reset on the cycle a fetch would complete.
    step(2);
    rst3 = 1'b1;
    step(1);
    rst3 = 1'b0;
    fill3(32'h1000);
    check("mid_addr", bus3.mem_address, 32'h1000);
    check("mid_cnt", count3, 32'h0);
    check("mid_valid", {31'h0, bus3.inst_valid}, 32'h0);
    check("mid_pc", bus3.inst_pc, 32'h0);
    check("mid_out", bus3.inst_out, 32'h0);
    step(3);
    check("mid_restart_cnt", count3, 32'd1);
    check("mid_restart_pc", bus3.inst_pc, 32'h1000);

    // Redirect aborting an in-progress fetch.
    step(1);
    redirect3 = 1'b1; rpc3 = 32'h2000;
    fill3(32'h2000);
    step(1);
    redirect3 = 1'b0;
    check("abort_cnt", count3, 32'd1);
    check("abort_addr", bus3.mem_address, 32'h2000);
    check("abort_valid", {31'h0, bus3.inst_valid}, 32'h0);
    step(2);
    check("abort_wait", {31'h0, bus3.inst_valid}, 32'h0);
    step(1);
    check("abort_first_cnt", count3, 32'd2);
    check("abort_first_pc", bus3.inst_pc, 32'h2000);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
